// File: rtl/findmax_stream_driver.sv
// Source side of the findMax streaming protocol: buffers host samples, replays
// them as one start-framed sequence, then captures the consumer's max value.
module findmax_stream_driver #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     go,
  output logic                     busy,
  output logic                     start,
  output logic [DATA_W-1:0]        stream_data,
  input  logic                     done_in,
  input  logic [DATA_W-1:0]        max_in,
  output logic [DATA_W-1:0]        result,
  output logic                     result_valid,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   rem;
  logic [TMR_W-1:0]   timer;

  logic go_accept, wr_accept, stream_next, capture, timeout_hit;

  assign full         = (count == CNT_FULL);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);

  // go outranks a same-cycle write, so the sequence uses the pre-write count.
  assign wr_accept = (state_q == S_IDLE) && wr_en && !full && !go_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    go_accept   = 1'b0;
    stream_next = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go && count != '0) begin
          go_accept = 1'b1;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rem == CNT_ONE) state_d = S_WAIT;
        else                stream_next = 1'b1;
      end
      S_WAIT: begin
        if (done_in) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (timer == TMR_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the sample buffer is reset along with the control state so a
  // replay after reset can never expose stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rem         <= '0;
      timer       <= '0;
      start       <= 1'b0;
      stream_data <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
        count       <= count + CNT_ONE;
      end

      // start/stream_data are registered: loaded on the edge that enters or
      // continues STREAM, zeroed on every other edge.
      if (go_accept || stream_next) begin
        start       <= 1'b1;
        stream_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + PTR_ONE;
      end else begin
        start       <= 1'b0;
        stream_data <= '0;
      end

      if (go_accept)        rem <= count;
      else if (stream_next) rem <= rem - CNT_ONE;

      if (state_q == S_WAIT) timer <= timer + TMR_ONE;
      else                   timer <= '0;

      if (go_accept)        timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;

      if (capture) result <= max_in;

      if (capture || timeout_hit) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_findmax_stream_driver.sv
// Directed bench for findmax_stream_driver with a small retained-max findMax
// consumer model that answers each sequence with a done pulse.
module tb_findmax_stream_driver;

  localparam int DEPTH   = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   go;
  logic                   busy;
  logic                   start;
  logic [DATA_W-1:0]      stream_data;
  logic                   done_in;
  logic [DATA_W-1:0]      max_in;
  logic [DATA_W-1:0]      result;
  logic                   result_valid;
  logic                   timeout_err;

  findmax_stream_driver #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .count        (count),
    .go           (go),
    .busy         (busy),
    .start        (start),
    .stream_data  (stream_data),
    .done_in      (done_in),
    .max_in       (max_in),
    .result       (result),
    .result_valid (result_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Consumer: running max that is only cleared on request, done one cycle
  // after start falls.
  logic             prev_start;
  logic             cons_en;
  logic             cons_clr;
  logic [DATA_W-1:0] cons_max;

  always @(posedge clk) begin
    prev_start <= start;
    if (cons_clr)                           cons_max <= '0;
    else if (start && stream_data > cons_max) cons_max <= stream_data;
  end

  assign done_in = cons_en & prev_start & ~start;
  assign max_in  = cons_max;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] got [64];
  int                got_n;
  logic [DATA_W-1:0] exp_s [64];
  int                exp_n;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // All tasks start and end right after a falling edge.
  task automatic write(input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic write_exp(input logic [DATA_W-1:0] d);
    write(d);
    exp_s[exp_n] = d;
    exp_n++;
  endtask

  task automatic clr_cons();
    cons_clr = 1'b1;
    @(negedge clk);
    cons_clr = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Records samples while start is high; returns in the first WAIT cycle.
  task automatic collect();
    got_n = 0;
    for (int i = 0; i < 40 && start; i++) begin
      got[got_n] = stream_data;
      got_n++;
      @(negedge clk);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++)
      check($sformatf("%s_s%0d", tag, i), got[i], exp_s[i]);
    exp_n = 0;
  endtask

  task automatic finish_seq(input string tag, input logic [DATA_W-1:0] exp_res);
    @(negedge clk);
    check({tag, "_rv"}, result_valid, 1);
    check({tag, "_result"}, result, exp_res);
    @(negedge clk);
    check({tag, "_rv_low"}, result_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_cnt0"}, count, 0);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    go       = 1'b0;
    cons_en  = 1'b1;
    cons_clr = 1'b1;
    exp_n    = 0;
    got_n    = 0;
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_data", stream_data, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_terr", timeout_err, 0);
    rst      = 1'b0;
    cons_clr = 1'b0;
    @(negedge clk);

    // Basic five-sample sequence.
    write_exp(8'd5); write_exp(8'd23); write_exp(8'd7); write_exp(8'd200); write_exp(8'd12);
    check("t1_count", count, 5);
    pulse_go();
    check("t1_busy", busy, 1);
    collect();
    check_stream("t1");
    finish_seq("t1", 8'd200);

    // Full buffer, overflow write dropped, 16-cycle replay.
    clr_cons();
    for (int i = 0; i < DEPTH; i++) write_exp(8'(i * 3 + 1));
    check("t2_full", full, 1);
    check("t2_count", count, 16);
    write(8'd99);
    check("t2_drop", count, 16);
    pulse_go();
    collect();
    check_stream("t2");
    finish_seq("t2", 8'd46);
    check("t2_notfull", full, 0);

    // go on an empty buffer is ignored.
    pulse_go();
    check("t3_nostart", start, 0);
    check("t3_nobusy", busy, 0);

    // Writes during STREAM are dropped.
    clr_cons();
    write_exp(8'd10); write_exp(8'd20); write_exp(8'd30);
    pulse_go();
    wr_en   = 1'b1;
    wr_data = 8'd77;
    collect();
    wr_en   = 1'b0;
    check_stream("t3w");
    finish_seq("t3w", 8'd30);

    // go and wr_en together in IDLE: go wins, write dropped.
    clr_cons();
    write_exp(8'd4); write_exp(8'd8);
    go      = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'd50;
    @(negedge clk);
    go      = 1'b0;
    wr_en   = 1'b0;
    collect();
    check_stream("t3g");
    finish_seq("t3g", 8'd8);

    // Timeout: no done pulse.
    cons_en = 1'b0;
    write_exp(8'd1); write_exp(8'd2); write_exp(8'd3);
    pulse_go();
    collect();
    check_stream("t4");
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) begin
        check("t4_early", timeout_err, 0);
        check("t4_wait_busy", busy, 1);
      end
    end
    check("t4_terr", timeout_err, 1);
    check("t4_idle", busy, 0);
    check("t4_cnt0", count, 0);
    check("t4_rv", result_valid, 0);
    cons_en = 1'b1;
    clr_cons();
    write_exp(8'd6);
    check("t4_sticky", timeout_err, 1);
    pulse_go();
    check("t4_clear", timeout_err, 0);
    collect();
    check_stream("t4b");
    finish_seq("t4b", 8'd6);

    // Reset in the second STREAM cycle.
    write(8'd11); write(8'd22); write(8'd33); write(8'd44);
    pulse_go();
    @(negedge clk);
    check("t5_mid", start, 1);
    rst = 1'b1;
    #1;
    check("t5_start", start, 0);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    clr_cons();
    write_exp(8'd9);
    pulse_go();
    collect();
    check_stream("t5");
    finish_seq("t5", 8'd9);

    // Consumer register retained across sequences.
    clr_cons();
    write_exp(8'd3); write_exp(8'd9); write_exp(8'd4);
    pulse_go();
    collect();
    check_stream("t6a");
    finish_seq("t6a", 8'd9);
    write_exp(8'd1); write_exp(8'd2);
    pulse_go();
    collect();
    check_stream("t6b");
    finish_seq("t6b", 8'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
